// File: rtl/seq_div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Holds the FSM state encoding, default widths and the bit-counter width helper.
package seq_div_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Enough bits to count DW iterations inclusive.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module div_step
  import seq_div_pkg::*;
#(
  parameter int VW = DEF_VW
) (
  input  logic [VW-1:0] r_in,
  input  logic          n_bit,
  input  logic [VW-1:0] d,
  output logic [VW-1:0] r_out,
  output logic          q_bit
);

  logic [VW:0] shifted;

  // The remainder stays below the divisor, so the shifted value needs one extra bit.
  assign shifted = {r_in, n_bit};
  assign q_bit   = (shifted >= {1'b0, d});
  assign r_out   = VW'(q_bit ? (shifted - {1'b0, d}) : shifted);

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro SEQ_DIV_DBZ_EN: divide-by-zero short-cut with a dbz flag.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int            CW   = cnt_width(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state, state_next;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] r_q;
  logic [DW-1:0] q_acc;
  logic [CW-1:0] cnt;
  logic [VW-1:0] r_next;
  logic          q_bit;
  logic [DW-1:0] q_shift;
  logic          calc_done;

  div_step #(.VW(VW)) u_step (
    .r_in  (r_q),
    .n_bit (dvd_q[DW-1]),
    .d     (dvs_q),
    .r_out (r_next),
    .q_bit (q_bit)
  );

  assign q_shift   = (q_acc << 1) | DW'(q_bit);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

`ifdef SEQ_DIV_DBZ_EN
  logic dbz_pend;
  logic dbz_q;

  // A zero divisor spends a single CALC cycle and then reports through dbz.
  assign calc_done = dbz_pend || (cnt == LAST);
  assign dbz       = dbz_q;
`else
  assign calc_done = (cnt == LAST);
  assign dbz       = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: assigning the default first keeps this block purely combinational;
  // any path that left state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (in_valid)  state_next = ST_CALC;
      ST_CALC: if (calc_done) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset alongside the FSM because an abort
  // must return the visible outputs to zero at once, not on the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      q_acc     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SEQ_DIV_DBZ_EN
      dbz_pend  <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            r_q      <= '0;
            q_acc    <= '0;
            cnt      <= '0;
`ifdef SEQ_DIV_DBZ_EN
            dbz_pend <= (divisor == '0);
`endif
          end
        end
        ST_CALC: begin
          dvd_q <= dvd_q << 1;
          r_q   <= r_next;
          q_acc <= q_shift;
          cnt   <= cnt + CW'(1);
          if (calc_done) begin
            quotient  <= q_shift;
            remainder <= r_next;
`ifdef SEQ_DIV_DBZ_EN
            if (dbz_pend) begin
              quotient  <= '1;
              remainder <= '0;
              dbz_q     <= 1'b1;
            end
`endif
          end
        end
`ifdef SEQ_DIV_DBZ_EN
        ST_DONE: begin
          if (out_ready) dbz_q <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed literal cases plus randomized
// operations scored against an arithmetic reference model.
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    res_t res;
    if (b == 0) begin
`ifdef SEQ_DIV_DBZ_EN
      res = '{q: '1, r: '0, z: 1'b1};
`else
      res = '{q: '1, r: a[VW-1:0], z: 1'b0};
`endif
    end else begin
      res = '{q: a / b, r: VW'(a % b), z: 1'b0};
    end
    return res;
  endfunction

  function automatic int model_latency(input logic [VW-1:0] b);
`ifdef SEQ_DIV_DBZ_EN
    if (b == 0) return 1;
`endif
    return (b == 0) ? DW : DW;
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("busy_while_valid", in_ready, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        check("quotient", quotient, exp_q[0].q);
        check("remainder", remainder, exp_q[0].r);
        check("dbz", dbz, exp_q[0].z);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int stall,
                        output logic [DW-1:0] q, output logic [VW-1:0] r,
                        output logic z, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b0;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid  = 1'($urandom);
      dividend  = DW'($urandom);
      divisor   = VW'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", lat, model_latency(b));
    q = quotient;
    r = remainder;
    z = dbz;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'(i);
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_handshake", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
    int            lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {quotient, remainder, dbz}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);

    run_op(8'd105, 4'd10, 0, q, r, z, lat);
    check("t1_lat", lat, 8);
    check("t1_q", q, 10);
    check("t1_r", r, 5);
    check("t1_dbz", z, 0);

    run_op(8'd225, 4'd15, 0, q, r, z, lat);
    check("t2_q", q, 15);
    check("t2_r", r, 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(DW'(a * b), VW'(b), 0, q, r, z, lat);
        check("chain_a", q, a);
        check("chain_r", r, 0);
      end
    end

    run_op(8'd7, 4'd9, 0, q, r, z, lat);
    check("t3_q_small", q, 0);
    check("t3_r_small", r, 7);
    run_op(8'd255, 4'd1, 0, q, r, z, lat);
    check("t3_q_max", q, 255);
    check("t3_r_max", r, 0);

    run_op(8'd200, 4'd0, 0, q, r, z, lat);
`ifdef SEQ_DIV_DBZ_EN
    check("t4_lat", lat, 1);
    check("t4_q", q, 8'hFF);
    check("t4_r", r, 0);
    check("t4_dbz", z, 1);
`else
    check("t4_lat", lat, 8);
    check("t4_q", q, 8'hFF);
    check("t4_r", r, 8);
    check("t4_dbz", z, 0);
`endif

    run_op(8'd77, 4'd6, 5, q, r, z, lat);
    check("t5_q", q, 12);
    check("t5_r", r, 5);

    // Abort mid-division: reset must clear state and outputs without a clock.
    in_valid = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_outputs", {quotient, remainder, dbz}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(8'd100, 4'd3, 0, q, r, z, lat);
    check("t6_q", q, 33);
    check("t6_r", r, 1);

    for (int i = 0; i < 200; i++) begin
      run_op(DW'($urandom), VW'($urandom), int'($urandom_range(0, 3)), q, r, z, lat);
    end

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
